// File: rtl/nerv_dmem_pkg.sv
// Shared types and constants for the NERV data-memory bridge.
package nerv_dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        RDATA
    } dmem_state_t;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/nerv_dmem_bridge_timeout.sv
// Request timeout for the dmem bridge: reloads on clear, counts down while enabled,
// and flags expiry on the last permitted cycle. Only instantiated with NERV_DMEM_TIMEOUT_EN.
module nerv_dmem_timeout #(
    parameter int CYCLES = 255
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= LOAD;
        end else if (i_clear) begin
            r_count <= LOAD;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Terminal count reached on the CYCLES-th enabled cycle after a clear.
    assign o_expire = i_enable && (r_count == '0);

endmodule

// File: rtl/nerv_dmem_bridge.sv
// Bridges the NERV single-cycle dmem port onto a valid/ready request + pulsed response bus.
// Optional request timeout with sticky bus_fault is built when NERV_DMEM_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | waiting for a core request
//   REQ   | bus_req_valid held until the bus accepts
//   WAIT  | request accepted, waiting for the response pulse
//   DONE  | transaction finished; core retires the re-presented request
//   RDATA | read data presented to the core; new requests ignored
module nerv_dmem_bridge
    import nerv_dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ext_stall,
    output logic        core_stall,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic [3:0]  bus_req_wstrb,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    output logic        bus_fault
);
    dmem_state_t r_state;
    logic        r_req_valid;
    logic [31:0] r_req_addr;
    logic [3:0]  r_req_wstrb;
    logic [31:0] r_req_wdata;
    logic [31:0] r_rdata_q;

    logic w_is_read;
    logic w_start;
    logic w_expire;

    assign w_is_read = (r_req_wstrb == WSTRB_READ);
    assign w_start   = (r_state == IDLE) && dmem_valid;

`ifdef NERV_DMEM_TIMEOUT_EN
    logic w_tmo_en;
    logic r_fault;

    assign w_tmo_en = (r_state == REQ) || (r_state == WAIT);

    nerv_dmem_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_clear  (w_start),
        .i_enable (w_tmo_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_expire) begin
            r_fault <= 1'b1;
        end
    end

    assign bus_fault = r_fault;
`else
    assign w_expire  = 1'b0;
    assign bus_fault = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_wstrb <= '0;
            r_req_wdata <= '0;
            r_rdata_q   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dmem_valid) begin
                        r_req_addr  <= dmem_addr;
                        r_req_wstrb <= dmem_wstrb;
                        r_req_wdata <= dmem_wdata;
                        r_req_valid <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (w_expire) begin
                        r_req_valid <= 1'b0;
                        r_rdata_q   <= '0;
                        r_state     <= DONE;
                    end else if (bus_req_ready) begin
                        r_req_valid <= 1'b0;
                        if (bus_rsp_valid) begin
                            if (w_is_read) r_rdata_q <= bus_rsp_rdata;
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_expire) begin
                        r_rdata_q <= '0;
                        r_state   <= DONE;
                    end else if (bus_rsp_valid) begin
                        if (w_is_read) r_rdata_q <= bus_rsp_rdata;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!ext_stall) r_state <= w_is_read ? RDATA : IDLE;
                end
                RDATA: begin
                    if (!ext_stall) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset gates the bridge's own stall terms so the core sees only ext_stall.
    assign core_stall = ext_stall |
                        (!reset & (w_start | (r_state == REQ) | (r_state == WAIT)));

    assign dmem_rdata    = r_rdata_q;
    assign bus_req_valid = r_req_valid;
    assign bus_req_addr  = r_req_addr;
    assign bus_req_wstrb = r_req_wstrb;
    assign bus_req_wdata = r_req_wdata;

endmodule

// File: tb/tb_nerv_dmem_bridge.sv
// Directed bench for nerv_dmem_bridge; timeout steps run when NERV_DMEM_TIMEOUT_EN is defined.
module tb_nerv_dmem_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ext_stall = 1'b0;
    logic        core_stall;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_req_addr;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = '0;
    logic        bus_fault;

    int checks = 0;
    int errors = 0;
    int n_hs = 0;
    int n_stall = 0;
    int hs0;
    int st0;

    nerv_dmem_bridge #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ext_stall     (ext_stall),
        .core_stall    (core_stall),
        .dmem_valid    (dmem_valid),
        .dmem_addr     (dmem_addr),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wstrb (bus_req_wstrb),
        .bus_req_wdata (bus_req_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_fault     (bus_fault)
    );

    always #5 clock = ~clock;

    // Edge-accurate counts of bus handshakes and core stall cycles.
    always @(posedge clock) begin
        if (bus_req_valid && bus_req_ready) n_hs = n_hs + 1;
        if (core_stall) n_stall = n_stall + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: core_stall follows ext_stall only.
        #1;
        ext_stall = 1'b1;
        #1 chk1("rst_stall_ext", core_stall, 1'b1);
        ext_stall = 1'b0;
        dmem_valid = 1'b1;
        #1 chk1("rst_stall_valid", core_stall, 1'b0);
        chk1("rst_req_valid", bus_req_valid, 1'b0);
        chk32("rst_req_addr", bus_req_addr, 32'h0);
        chk32("rst_rdata", dmem_rdata, 32'h0);
        chk1("rst_fault", bus_fault, 1'b0);
        dmem_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        // 1: zero-wait write
        hs0 = n_hs;
        st0 = n_stall;
        dmem_addr = 32'h100;
        dmem_wstrb = 4'b1111;
        dmem_wdata = 32'hDEADBEEF;
        dmem_valid = 1'b1;
        #1 chk1("t1_idle_stall", core_stall, 1'b1);
        chk1("t1_idle_noreq", bus_req_valid, 1'b0);
        cyc();
        chk1("t1_req_valid", bus_req_valid, 1'b1);
        chk32("t1_req_addr", bus_req_addr, 32'h100);
        chk32("t1_req_wstrb", 32'(bus_req_wstrb), 32'hF);
        chk32("t1_req_wdata", bus_req_wdata, 32'hDEADBEEF);
        chk1("t1_req_stall", core_stall, 1'b1);
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hCAFEF00D;
        cyc();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        #1 chk1("t1_done_noreq", bus_req_valid, 1'b0);
        chk1("t1_done_nostall", core_stall, 1'b0);
        chk32("t1_write_no_rdata", dmem_rdata, 32'h0);
        cyc();
        dmem_valid = 1'b0;
        #1 chk1("t1_idle_nostall", core_stall, 1'b0);
        cyc();
        chk1("t1_no_reissue", bus_req_valid, 1'b0);
        chk32("t1_handshakes", 32'(n_hs - hs0), 32'd1);
        chk32("t1_stall_cycles", 32'(n_stall - st0), 32'd2);

        // 2: read with ready on 3rd REQ cycle, response on 2nd WAIT cycle
        hs0 = n_hs;
        st0 = n_stall;
        dmem_addr = 32'h200;
        dmem_wstrb = 4'b0000;
        dmem_wdata = 32'h11111111;
        dmem_valid = 1'b1;
        cyc();
        chk1("t2_req1_valid", bus_req_valid, 1'b1);
        chk32("t2_req_addr", bus_req_addr, 32'h200);
        chk32("t2_req_wstrb", 32'(bus_req_wstrb), 32'h0);
        cyc();
        chk1("t2_req2_valid", bus_req_valid, 1'b1);
        cyc();
        chk1("t2_req3_valid", bus_req_valid, 1'b1);
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        #1 chk1("t2_wait_noreq", bus_req_valid, 1'b0);
        chk1("t2_wait_stall", core_stall, 1'b1);
        cyc();
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h12345678;
        cyc();
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'h0;
        #1 chk1("t2_done_nostall", core_stall, 1'b0);
        cyc();
        dmem_valid = 1'b0;
        #1 chk32("t2_rdata", dmem_rdata, 32'h12345678);
        chk1("t2_rdata_nostall", core_stall, 1'b0);
        chk32("t2_stall_cycles", 32'(n_stall - st0), 32'd6);
        chk32("t2_handshakes", 32'(n_hs - hs0), 32'd1);
        cyc();

        // 3/4: zero-wait read, ext_stall in DONE and RDATA, store presented during RDATA
        dmem_addr = 32'h300;
        dmem_wstrb = 4'b0000;
        dmem_valid = 1'b1;
        cyc();
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hA5A50001;
        cyc();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        ext_stall = 1'b1;
        hs0 = n_hs;
        #1 chk1("t3_done_extstall", core_stall, 1'b1);
        chk32("t3_rdata", dmem_rdata, 32'hA5A50001);
        cyc();
        chk1("t3_done_hold1", bus_req_valid, 1'b0);
        cyc();
        chk1("t3_done_hold2", bus_req_valid, 1'b0);
        chk32("t3_rdata_hold", dmem_rdata, 32'hA5A50001);
        ext_stall = 1'b0;
        cyc();
        ext_stall = 1'b1;
        dmem_addr = 32'h400;
        dmem_wstrb = 4'b0011;
        dmem_wdata = 32'h0000BEEF;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hBAD0BAD0;
        cyc();
        bus_rsp_valid = 1'b0;
        #1 chk1("t3_rdata_hold_noreq", bus_req_valid, 1'b0);
        chk32("t3_spurious_rsp", dmem_rdata, 32'hA5A50001);
        chk1("t3_rdata_extstall", core_stall, 1'b1);
        cyc();
        chk1("t4_rdata_noreq", bus_req_valid, 1'b0);
        ext_stall = 1'b0;
        #1 chk1("t4_rdata_ignores_valid", core_stall, 1'b0);
        chk32("t4_no_handshake", 32'(n_hs - hs0), 32'd0);
        cyc();
        chk1("t4_idle_stall", core_stall, 1'b1);
        chk1("t4_idle_noreq", bus_req_valid, 1'b0);
        cyc();
        chk1("t4_req_valid", bus_req_valid, 1'b1);
        chk32("t4_req_addr", bus_req_addr, 32'h400);
        chk32("t4_req_wstrb", 32'(bus_req_wstrb), 32'h3);
        chk32("t4_req_wdata", bus_req_wdata, 32'h0000BEEF);
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hFFFFFFFF;
        cyc();
        bus_rsp_valid = 1'b0;
        #1 chk32("t4_write_keeps_rdata", dmem_rdata, 32'hA5A50001);
        chk1("t4_done_nostall", core_stall, 1'b0);
        cyc();
        dmem_valid = 1'b0;
        #1 chk1("t4_idle_nostall", core_stall, 1'b0);
`ifndef NERV_DMEM_TIMEOUT_EN
        chk1("t4_fault_tied", bus_fault, 1'b0);
`endif

`ifdef NERV_DMEM_TIMEOUT_EN
        // 6: read that never gets ready; timeout after 8 cycles
        dmem_addr = 32'h600;
        dmem_wstrb = 4'b0000;
        dmem_valid = 1'b1;
        cyc();
        chk1("t6_fault_before", bus_fault, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk1("t6_req_held", bus_req_valid, 1'b1);
            cyc();
        end
        chk1("t6_req_dropped", bus_req_valid, 1'b0);
        chk1("t6_fault_set", bus_fault, 1'b1);
        chk32("t6_rdata_zero", dmem_rdata, 32'h0);
        chk1("t6_done_nostall", core_stall, 1'b0);
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h77777777;
        cyc();
        bus_rsp_valid = 1'b0;
        dmem_valid = 1'b0;
        #1 chk32("t6_late_rsp_ignored", dmem_rdata, 32'h0);
        cyc();
        chk1("t6_fault_sticky", bus_fault, 1'b1);
`endif

        // 5: async reset in WAIT, then a spurious response
        dmem_addr = 32'h500;
        dmem_wstrb = 4'b0000;
        dmem_valid = 1'b1;
        cyc();
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        reset = 1'b1;
        #1 chk1("t5_rst_noreq", bus_req_valid, 1'b0);
        chk1("t5_rst_stall", core_stall, 1'b0);
        chk32("t5_rst_addr", bus_req_addr, 32'h0);
        chk1("t5_rst_fault", bus_fault, 1'b0);
        dmem_valid = 1'b0;
        cyc();
        reset = 1'b0;
        #1 chk1("t5_idle_nostall", core_stall, 1'b0);
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hBAD0BAD0;
        cyc();
        bus_rsp_valid = 1'b0;
        #1 chk32("t5_spurious_ignored", dmem_rdata, 32'h0);
        chk1("t5_after_noreq", bus_req_valid, 1'b0);

        // Reset while REQ drops bus_req_valid without waiting for a clock
        dmem_addr = 32'h700;
        dmem_wstrb = 4'b1111;
        dmem_valid = 1'b1;
        cyc();
        chk1("t5b_req_valid", bus_req_valid, 1'b1);
        #2 reset = 1'b1;
        #1 chk1("t5b_rst_drop", bus_req_valid, 1'b0);
        dmem_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
